// File: rtl/decoder_pipe_pkg.sv
// Shared types and the decode function for decoder_pipe.
// Holds buffer-state and mode enums, counter width and decode().
package decoder_pipe_pkg;

  localparam int ERR_CNT_W = 8;
  localparam int DEC_MAX_W = 256;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_e;

  typedef enum logic {
    MODE_ONEHOT = 1'b0,
    MODE_THERMO = 1'b1
  } mode_e;

  // Returns {err, vector}; the vector is DEC_MAX_W wide and the
  // caller keeps only its low `width` bits.
  function automatic logic [DEC_MAX_W:0] decode(
    input logic [7:0] code,
    input mode_e      mode,
    input int         width
  );
    logic [DEC_MAX_W:0] r;
    logic               err;
    int                 c;
    c   = {24'd0, code};
    r   = '0;
    err = (c >= width);
    for (int i = 0; i < DEC_MAX_W; i++) begin
      if (!err && i < width) begin
        if (mode == MODE_THERMO) r[i] = (i <= c);
        else                     r[i] = (i == c);
      end
    end
    r[DEC_MAX_W] = err;
    return r;
  endfunction

endpackage

// File: rtl/dec_skid_buf.sv
// Generic 2-entry FIFO-ordered valid/ready buffer, head registered on out_data.
// Ports: clk, rst, in_valid/in_ready/in_data, out_valid/out_ready/out_data.
module dec_skid_buf
  import decoder_pipe_pkg::*;
#(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  buf_state_e   state;
  logic [W-1:0] tail;
  logic         accept;
  logic         emit;

  assign accept = in_valid & in_ready;
  assign emit   = out_valid & out_ready;

  // in_ready/out_valid are flops tracking state, so the
  // input side never sees out_ready combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      tail      <= '0;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            out_data  <= in_data;
            out_valid <= 1'b1;
            state     <= ONE;
          end
        end
        ONE: begin
          if (accept && emit) begin
            out_data <= in_data;
          end else if (accept) begin
            tail     <= in_data;
            in_ready <= 1'b0;
            state    <= FULL;
          end else if (emit) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (emit) begin
            out_data <= tail;
            in_ready <= 1'b1;
            state    <= ONE;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/decoder_pipe.sv
// Registered one-hot/thermometer decoder with 2-entry output buffer.
// Ports: clk, rst, in_*/out_* handshakes, out_err, err_cnt.
// err_cnt counting is built only when DECODER_PIPE_ERR_CNT_EN is defined.
module decoder_pipe
  import decoder_pipe_pkg::*;
#(
  parameter int IN_WIDTH  = 3,
  parameter int OUT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in,
  input  logic                 in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  if (IN_WIDTH < 1 || IN_WIDTH > 8 ||
      OUT_WIDTH < 2 || OUT_WIDTH > (1 << IN_WIDTH)) begin : g_bad
    $error("decoder_pipe: illegal IN_WIDTH/OUT_WIDTH");
  end

  logic [7:0]           code;
  logic [DEC_MAX_W:0]   dec;
  logic [OUT_WIDTH:0]   pay;
  logic [OUT_WIDTH:0]   head;
  logic                 unused_dec;

  always_comb begin
    code = '0;
    code[IN_WIDTH-1:0] = in;
  end

  assign dec = decode(code, mode_e'(in_mode), OUT_WIDTH);
  assign pay = {dec[DEC_MAX_W], dec[OUT_WIDTH-1:0]};
  assign unused_dec = ^dec;

  dec_skid_buf #(
    .W(OUT_WIDTH + 1)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (pay),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (head)
  );

  assign out     = head[OUT_WIDTH-1:0];
  assign out_err = head[OUT_WIDTH];

`ifdef DECODER_PIPE_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (in_valid && in_ready &&
                 dec[DEC_MAX_W] && !(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign err_cnt = cnt;
`else
  assign err_cnt = '0;
`endif

endmodule

// File: tb/tb_decoder_pipe.sv
// Scoreboard bench for decoder_pipe: OUT_WIDTH=8 and OUT_WIDTH=6 instances.
// Both instances share stimulus; expected beats are queued on accept.
module tb_decoder_pipe;
  import decoder_pipe_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] code;
  logic       mode;
  logic       out_ready;

  logic       rdy8, ov8, oe8;
  logic [7:0] o8, ec8;
  logic       rdy6, ov6, oe6;
  logic [5:0] o6;
  logic [7:0] ec6;

  int n_chk  = 0;
  int n_pass = 0;
  bit rand_bp = 1'b0;

  logic [8:0] q8[$];
  logic [6:0] q6[$];
  int         m8 = 0;
  int         m6 = 0;
  bit         hold8 = 1'b0;
  logic [8:0] last8 = '0;

  always #5 clk = ~clk;

  decoder_pipe #(.IN_WIDTH(3), .OUT_WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy8),
    .in(code), .in_mode(mode),
    .out_valid(ov8), .out_ready(out_ready),
    .out(o8), .out_err(oe8), .err_cnt(ec8)
  );

  decoder_pipe #(.IN_WIDTH(3), .OUT_WIDTH(6)) u_dut6 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(rdy6),
    .in(code), .in_mode(mode),
    .out_valid(ov6), .out_ready(out_ready),
    .out(o6), .out_err(oe6), .err_cnt(ec6)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic int cnt_inc(input int x);
`ifdef DECODER_PIPE_ERR_CNT_EN
    return (x < 255) ? x + 1 : 255;
`else
    return 0;
`endif
  endfunction

  function automatic int cnt_exp(input int x);
`ifdef DECODER_PIPE_ERR_CNT_EN
    return x;
`else
    return 0 * x;
`endif
  endfunction

  // Monitor/scoreboard: pop on emit, then push on accept.
  always @(negedge clk) begin
    logic [DEC_MAX_W:0] r;
    if (rst) begin
      q8.delete();
      q6.delete();
      m8 = 0;
      m6 = 0;
      hold8 = 1'b0;
    end else begin
      check("cnt8", ec8, m8);
      check("cnt6", ec6, m6);
      if (hold8) check("hold8", {oe8, o8}, last8);
      if (ov8 && out_ready) begin
        if (q8.size() == 0) check("extra8", 1, 0);
        else check("data8", {oe8, o8}, q8.pop_front());
      end
      if (ov6 && out_ready) begin
        if (q6.size() == 0) check("extra6", 1, 0);
        else check("data6", {oe6, o6}, q6.pop_front());
      end
      hold8 = ov8 && !out_ready;
      last8 = {oe8, o8};
      if (in_valid && rdy8) begin
        r = decode({5'd0, code}, mode_e'(mode), 8);
        q8.push_back({r[DEC_MAX_W], r[7:0]});
        if (r[DEC_MAX_W]) m8 = cnt_inc(m8);
      end
      if (in_valid && rdy6) begin
        r = decode({5'd0, code}, mode_e'(mode), 6);
        q6.push_back({r[DEC_MAX_W], r[5:0]});
        if (r[DEC_MAX_W]) m6 = cnt_inc(m6);
      end
    end
  end

  task automatic send(input logic [2:0] c, input logic m,
                      output int waits);
    waits = 0;
    in_valid = 1'b1;
    code = c;
    mode = m;
    if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    while (!rdy8 && waits < 50) begin
      @(posedge clk);
      #1;
      waits++;
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
    end
    if (waits >= 50) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    logic [7:0] e;
    logic [7:0] th_exp [3];
    logic [2:0] th_in  [3];
    th_in  = '{3'd0, 3'd3, 3'd7};
    th_exp = '{8'h01, 8'h0F, 8'hFF};

    rst = 1'b1;
    in_valid = 1'b0;
    code = '0;
    mode = 1'b0;
    out_ready = 1'b1;
    do_reset();
    check("rst_valid", ov8, 0);
    check("rst_ready", rdy8, 1);
    check("rst_out", o8, 0);
    check("rst_err", oe8, 0);
    check("rst_cnt", ec8, 0);

    for (int i = 0; i < 8; i++) begin
      send(3'(i), 1'b0, w);
      e = 8'd1 << i;
      check("oh_stall", w, 0);
      check("oh_valid", ov8, 1);
      check("oh_out", o8, e);
      check("oh_err", oe8, 0);
    end
    idle(2);
    check("oh_cnt", ec8, 0);

    for (int i = 0; i < 3; i++) begin
      send(th_in[i], 1'b1, w);
      check("th_out", o8, th_exp[i]);
    end
    idle(2);

    do_reset();
    send(3'd6, 1'b0, w);
    check("oor6_out", o6, 0);
    check("oor6_err", oe6, 1);
    send(3'd7, 1'b1, w);
    check("oor7_out", o6, 0);
    check("oor7_err", oe6, 1);
    idle(2);
    check("oor_cnt2", ec6, cnt_exp(2));
    check("oor_cnt8", ec8, 0);
    for (int i = 0; i < 300; i++) begin
      send(3'(6 + (i % 2)), 1'(i % 2), w);
    end
    idle(2);
    check("oor_sat", ec6, cnt_exp(255));

    out_ready = 1'b0;
    send(3'd1, 1'b0, w);
    send(3'd2, 1'b1, w);
    in_valid = 1'b1;
    code = 3'd3;
    mode = 1'b0;
    check("bp_full", rdy8, 0);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("bp_stay", rdy8, 0);
      check("bp_head", o8, 8'h02);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_rise", rdy8, 1);
    check("bp_head2", o8, 8'h07);
    @(posedge clk);
    #1;
    check("bp_third", o8, 8'h08);
    idle(3);

    rand_bp = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send(3'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), w);
    end
    rand_bp = 1'b0;
    out_ready = 1'b1;
    idle(4);
    check("rnd_q8", q8.size(), 0);
    check("rnd_q6", q6.size(), 0);

    out_ready = 1'b0;
    send(3'd1, 1'b0, w);
    send(3'd7, 1'b0, w);
    rst = 1'b1;
    in_valid = 1'b1;
    code = 3'd4;
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    check("mr_valid", ov8, 0);
    check("mr_ready", rdy8, 1);
    check("mr_cnt8", ec8, 0);
    check("mr_cnt6", ec6, 0);
    out_ready = 1'b1;
    idle(5);
    check("mr_none", ov8, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/decoder_pipe.md
# decoder_pipe

Parametrised, registered binary-to-one-hot/thermometer decoder with valid/ready handshakes on both sides and a two-entry output buffer, sustaining one decode per cycle under backpressure. It replaces the purely combinational decoder wherever the decoded vector drives a registered consumer, such as grant vectors, write-enable fans or bank selects. Out-of-range codes are flagged with a per-beat error bit and, optionally, counted.

## Interface
- IN_WIDTH, 3, width of binary input code; legal range 1..8
- OUT_WIDTH, 8, width of decoded vector; legal range 2..2**IN_WIDTH, checked at elaboration
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat present
- in_ready  out  1  block can accept a beat this cycle
- in  in  IN_WIDTH  binary code
- in_mode  in  1  0 = one-hot, 1 = thermometer; sampled with the beat
- out_valid  out  1  output beat present
- out_ready  in  1  consumer accepts beat
- out  out  OUT_WIDTH  decoded vector
- out_err  out  1  beat's code was out of range (in >= OUT_WIDTH)
- err_cnt  out  8  saturating count of accepted out-of-range beats (see Configuration)

## Operation
- Accept on in_valid & in_ready; emit on out_valid & out_ready.
- Decode at accept time:
  - One-hot: out = 1 << in.
  - Thermometer: out bits [in:0] set, the rest clear. Example: in=2 gives 0000_0111.
  - Out of range (in >= OUT_WIDTH, either mode): out = 0 and out_err = 1. The beat still flows and is never dropped.
- Output buffer is 2 entries, FIFO-ordered, with head presented on out/out_err. State machine, encoded in the package:
  - EMPTY: accept → ONE.
  - ONE: accept & !emit → FULL; emit & !accept → EMPTY; accept & emit → ONE (head replaced by the new beat).
  - FULL: emit → ONE. No accept is possible.
- in_ready = (state != FULL). It is a function of registered state only, with no combinational path from out_ready.
- out_valid = (state != EMPTY).
- Data and err of a held head stay stable while out_valid & !out_ready.
- err_cnt increments on accept of an out-of-range beat and saturates at 255. It is not affected by emit or backpressure.
- Reset values: state EMPTY, out_valid 0, in_ready 1 from the first cycle after reset, out 0, out_err 0, err_cnt 0.
- Reset mid-operation discards all buffered beats without emitting them. Beats presented while rst=1 are not accepted.

## Timing
- Latency: a beat accepted in cycle N appears on out with out_valid=1 in cycle N+1.
- Throughput: 1 beat/cycle while out_ready=1.
- When out_ready drops, at most 2 beats are absorbed; in_ready falls in the cycle after the second accept.
- FULL with out_ready=1: the head emits this cycle; in_ready rises in the next cycle, giving one bubble on the input side. This is accepted by design.
- No combinational path from in to out; out and out_err are register outputs.
- The error count increments the cycle after the offending accept.

## Configuration
- DECODER_PIPE_ERR_CNT_EN defined: the 8-bit saturating counter is implemented and drives err_cnt.
- Undefined: the counter logic is removed and err_cnt is tied to 0. out_err per beat is unaffected.

## Structure
- Package decoder_pipe_pkg holds:
  - buffer state enum (EMPTY, ONE, FULL)
  - decode-mode enum (MODE_ONEHOT, MODE_THERMO)
  - ERR_CNT_W = 8
  - decode function f(code, mode) returning {err, vector}, shared with the bench's model
- Sub-module dec_skid_buf: a generic 2-entry valid/ready buffer, parametrised by payload width (OUT_WIDTH+1). decoder_pipe holds the decode function, the error counter and one dec_skid_buf instance.

## Test plan
- Full sweep, out_ready=1, one-hot: in=0..7 back-to-back → out=1<<in one cycle later with no bubbles; out_err=0; err_cnt=0.
- Thermometer: in_mode=1, in=0,3,7 → out=0x01, 0x0F, 0xFF.
- Out of range with OUT_WIDTH=6, IN_WIDTH=3: in=6 then 7 → out=0, out_err=1 on both beats; err_cnt=2. Repeat 300 such beats → err_cnt stays at 255.
- Backpressure: out_ready=0 and send 3 beats → first 2 accepted, in_ready=0 after the second. Raise out_ready → beats delivered in order with data held stable; in_ready returns 1 one cycle after the first emit.
- Simultaneous accept/emit in ONE with random 50% out_ready over 1000 beats → output sequence equals the input sequence with no loss or duplication. Compare against the package decode function.
- Reset mid-stream with 2 beats buffered: assert rst for 1 cycle → next cycle out_valid=0, in_ready=1, err_cnt=0; buffered beats are never emitted.
